// File: rtl/apb_protocol_monitor.sv
// Passive APB tap: follows SETUP/ACCESS phases on the observed wires and reports
// handshake violations as registered pulses and sticky flags, plus saturating transfer/error counts.
module apb_protocol_monitor #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 32,
  parameter int NUM_SEL    = 1,
  parameter int TIMEOUT    = 16,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                    PCLK,
  input  logic                    PRESET_n,
  input  logic [NUM_SEL-1:0]      PSEL,
  input  logic                    PENABLE,
  input  logic                    PWRITE,
  input  logic [ADDR_WIDTH-1:0]   PADDR,
  input  logic [DATA_WIDTH-1:0]   PWDATA,
  input  logic [DATA_WIDTH/8-1:0] PSTRB,
  input  logic                    PREADY,
  input  logic                    PSLVERR,
  input  logic                    clr,
  output logic [7:0]              viol_flags,
  output logic [7:0]              viol_pulse,
  output logic [CNT_WIDTH-1:0]    xfer_count,
  output logic [CNT_WIDTH-1:0]    err_count,
  output logic                    busy
);

  localparam int SW = DATA_WIDTH / 8;
  localparam int WW = $clog2(TIMEOUT + 1);
  localparam logic [WW-1:0] WAIT_LAST = WW'(TIMEOUT - 1);
  localparam logic [WW-1:0] WAIT_MAX  = WW'(TIMEOUT);

  // state  | meaning
  // IDLE   | no transfer open
  // SETUP  | setup phase sampled last edge, access phase expected now
  // ACCESS | access wait state sampled last edge, transfer still open
  typedef enum logic [1:0] {S_IDLE, S_SETUP, S_ACCESS} state_t;

  state_t                state, state_nxt;
  logic [NUM_SEL-1:0]    cap_sel;
  logic [ADDR_WIDTH-1:0] cap_addr;
  logic                  cap_write;
  logic [DATA_WIDTH-1:0] cap_wdata;
  logic [SW-1:0]         cap_strb;
  logic [WW-1:0]         wait_cnt;
  logic                  done_q;

  logic [7:0] viol_vec;
  logic       setup_req, sel_match, fields_differ;
  logic       capture, access_cycle, complete;

  always_comb begin
    setup_req     = (|PSEL) && !PENABLE;
    sel_match     = (PSEL == cap_sel);
    fields_differ = (PADDR != cap_addr) || (PWRITE != cap_write) || (PSTRB != cap_strb) ||
                    (cap_write && (PWDATA != cap_wdata));
    viol_vec      = '0;
    state_nxt     = state;
    capture       = 1'b0;
    access_cycle  = 1'b0;
    complete      = 1'b0;

    viol_vec[0] = ($countones(PSEL) > 1);
    viol_vec[1] = PENABLE && !(|PSEL);
    viol_vec[6] = done_q && PENABLE;

    case (state)
      S_IDLE: begin
        if ((|PSEL) && PENABLE) viol_vec[2] = 1'b1;
        else if (setup_req)     capture     = 1'b1;
      end
      S_SETUP: begin
        if (PENABLE && sel_match) begin
          access_cycle = 1'b1;
          viol_vec[3]  = fields_differ;
        end else begin
          viol_vec[2] = 1'b1;
          capture     = setup_req;
          state_nxt   = S_IDLE;
        end
      end
      S_ACCESS: begin
        access_cycle = 1'b1;
        viol_vec[3]  = !sel_match || fields_differ;
      end
      default: state_nxt = S_IDLE;
    endcase

    if (capture) begin
      state_nxt   = S_SETUP;
      viol_vec[5] = !PWRITE && (|PSTRB);
    end

    // The sampled cycle is an access phase: either it completes or it is a wait state.
    if (access_cycle) begin
      if (PREADY) begin
        complete  = 1'b1;
        state_nxt = S_IDLE;
      end else begin
        state_nxt   = S_ACCESS;
        viol_vec[4] = (wait_cnt == WAIT_LAST);
      end
    end
  end

  always_ff @(posedge PCLK or negedge PRESET_n) begin
    if (!PRESET_n) begin
      state      <= S_IDLE;
      cap_sel    <= '0;
      cap_addr   <= '0;
      cap_write  <= 1'b0;
      cap_wdata  <= '0;
      cap_strb   <= '0;
      wait_cnt   <= '0;
      done_q     <= 1'b0;
      viol_flags <= '0;
      viol_pulse <= '0;
      xfer_count <= '0;
      err_count  <= '0;
      busy       <= 1'b0;
    end else begin
      state  <= state_nxt;
      done_q <= complete;
      busy   <= capture || access_cycle;

      if (capture) begin
        cap_sel   <= PSEL;
        cap_addr  <= PADDR;
        cap_write <= PWRITE;
        cap_wdata <= PWDATA;
        cap_strb  <= PSTRB;
      end

      if (access_cycle && !PREADY) begin
        if (wait_cnt != WAIT_MAX) wait_cnt <= wait_cnt + WW'(1);
      end else begin
        wait_cnt <= '0;
      end

      viol_pulse <= viol_vec;

      // New events in the clearing cycle survive the clear.
      if (clr) begin
        viol_flags <= viol_vec;
        xfer_count <= CNT_WIDTH'(complete);
        err_count  <= CNT_WIDTH'(complete & PSLVERR);
      end else begin
        viol_flags <= viol_flags | viol_vec;
        if (complete && (xfer_count != '1))
          xfer_count <= xfer_count + CNT_WIDTH'(1);
        if (complete && PSLVERR && (err_count != '1))
          err_count <= err_count + CNT_WIDTH'(1);
      end
    end
  end

endmodule

// File: tb/tb_apb_protocol_monitor.sv
// Bench for apb_protocol_monitor: directed scenarios plus random bus traffic, every cycle
// checked against a transfer-level reference model of the APB handshake rules.
module tb_apb_protocol_monitor;
  localparam int TIMEOUT = 16;
  localparam int CMAX    = 15;

  logic        PCLK = 1'b0;
  logic        PRESET_n = 1'b0;
  logic [3:0]  PSEL = '0;
  logic        PENABLE = 1'b0, PWRITE = 1'b0, PREADY = 1'b0, PSLVERR = 1'b0, clr = 1'b0;
  logic [7:0]  PADDR = '0;
  logic [31:0] PWDATA = '0;
  logic [3:0]  PSTRB = '0;
  logic [7:0]  viol_flags, viol_pulse;
  logic [3:0]  xfer_count, err_count;
  logic        busy;

  always #5 PCLK = ~PCLK;

  apb_protocol_monitor #(
    .ADDR_WIDTH(8), .DATA_WIDTH(32), .NUM_SEL(4), .TIMEOUT(TIMEOUT), .CNT_WIDTH(4)
  ) dut (
    .PCLK(PCLK), .PRESET_n(PRESET_n), .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE),
    .PADDR(PADDR), .PWDATA(PWDATA), .PSTRB(PSTRB), .PREADY(PREADY), .PSLVERR(PSLVERR),
    .clr(clr), .viol_flags(viol_flags), .viol_pulse(viol_pulse), .xfer_count(xfer_count),
    .err_count(err_count), .busy(busy)
  );

  int n_vec = 0;
  int n_bad = 0;

  task automatic chk_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: observed %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: phase 0 = no transfer, 1 = setup seen, 2 = inside access wait states.
  int          m_phase, m_waits, m_xfer, m_err;
  bit          m_done_prev, m_busy;
  logic [7:0]  m_flags, m_pulse;
  logic [3:0]  c_sel, c_strb;
  logic [7:0]  c_addr;
  logic        c_wr;
  logic [31:0] c_data;

  task automatic model_reset();
    m_phase = 0; m_waits = 0; m_xfer = 0; m_err = 0;
    m_done_prev = 0; m_busy = 0; m_flags = '0; m_pulse = '0;
    c_sel = '0; c_strb = '0; c_addr = '0; c_wr = 0; c_data = '0;
  endtask

  task automatic model_step();
    logic [7:0] v;
    bit done, take, acc, differ;
    int nxt;
    v = '0; done = 0; take = 0; acc = 0; nxt = m_phase;
    differ = (PADDR !== c_addr) || (PWRITE !== c_wr) || (PSTRB !== c_strb) ||
             (c_wr && (PWDATA !== c_data));
    if ($countones(PSEL) > 1) v[0] = 1'b1;
    if (PENABLE && PSEL == 0) v[1] = 1'b1;
    if (m_done_prev && PENABLE) v[6] = 1'b1;
    if (m_phase == 0) begin
      if (PSEL != 0 && PENABLE) v[2] = 1'b1;
      else if (PSEL != 0) take = 1;
    end else if (m_phase == 1) begin
      if (PENABLE && PSEL == c_sel) begin
        acc = 1;
        if (differ) v[3] = 1'b1;
      end else begin
        v[2] = 1'b1;
        nxt = 0;
        if (PSEL != 0 && !PENABLE) take = 1;
      end
    end else begin
      acc = 1;
      if (differ || PSEL != c_sel) v[3] = 1'b1;
    end
    if (take) begin
      c_sel = PSEL; c_addr = PADDR; c_wr = PWRITE; c_data = PWDATA; c_strb = PSTRB;
      if (!PWRITE && PSTRB != 0) v[5] = 1'b1;
      nxt = 1;
    end
    if (acc) begin
      if (PREADY) begin
        done = 1; nxt = 0; m_waits = 0;
      end else begin
        m_waits++;
        nxt = 2;
        if (m_waits == TIMEOUT) v[4] = 1'b1;
      end
    end else begin
      m_waits = 0;
    end
    m_pulse = v;
    if (clr) begin
      m_flags = v;
      m_xfer  = int'(done);
      m_err   = int'(done && PSLVERR);
    end else begin
      m_flags = m_flags | v;
      m_xfer  = (m_xfer + int'(done) > CMAX) ? CMAX : m_xfer + int'(done);
      m_err   = (m_err + int'(done && PSLVERR) > CMAX) ? CMAX : m_err + int'(done && PSLVERR);
    end
    m_busy = take || acc;
    m_done_prev = done;
    m_phase = nxt;
  endtask

  task automatic tick();
    @(posedge PCLK);
    model_step();
    #1;
    chk_val("viol_pulse", 32'(viol_pulse), 32'(m_pulse));
    chk_val("viol_flags", 32'(viol_flags), 32'(m_flags));
    chk_val("xfer_count", 32'(xfer_count), 32'(m_xfer));
    chk_val("err_count",  32'(err_count),  32'(m_err));
    chk_val("busy",       32'(busy),       32'(m_busy));
  endtask

  task automatic bus_idle();
    PSEL = '0; PENABLE = 0; PREADY = 0; PSLVERR = 0;
  endtask

  task automatic do_clr();
    bus_idle();
    clr = 1; tick(); clr = 0;
  endtask

  task automatic xfer(input int sel, input bit wr, input logic [7:0] a, input logic [31:0] d,
                      input logic [3:0] s, input int waits, input bit err, output int nb);
    nb = 0;
    PSEL = 4'(1 << sel); PENABLE = 0; PWRITE = wr; PADDR = a; PWDATA = d; PSTRB = s;
    PREADY = 0; PSLVERR = 0;
    tick(); nb += int'(busy);
    PENABLE = 1;
    for (int i = 0; i < waits; i++) begin
      tick(); nb += int'(busy);
    end
    PREADY = 1; PSLVERR = err;
    tick(); nb += int'(busy);
    bus_idle();
  endtask

  initial begin
    int nb, to_pulses, r, w;
    logic [3:0] s;
    model_reset();
    #12;
    chk_val("rst_flags", 32'(viol_flags), 32'h0);
    chk_val("rst_xfer",  32'(xfer_count), 32'h0);
    chk_val("rst_busy",  32'(busy), 32'h0);
    PRESET_n = 1;

    // 1: zero-wait write
    xfer(0, 1, 8'h10, 32'hDEADBEEF, 4'hF, 0, 0, nb);
    chk_val("t1_busy_cycles", 32'(nb), 32'd2);
    chk_val("t1_xfer", 32'(xfer_count), 32'd1);
    chk_val("t1_flags", 32'(viol_flags), 32'h0);
    tick();

    // 2: read, three wait states, slave error
    do_clr();
    xfer(1, 0, 8'h20, 32'h0, 4'h0, 3, 1, nb);
    chk_val("t2_err", 32'(err_count), 32'd1);
    chk_val("t2_xfer", 32'(xfer_count), 32'd1);
    chk_val("t2_no_timeout", 32'(viol_flags[4]), 32'd0);
    tick();

    // 3: two selects at once
    do_clr();
    PSEL = 4'b0101; PWRITE = 1; PSTRB = 4'hF;
    tick();
    chk_val("t3_pulse", 32'(viol_pulse), 32'h01);
    bus_idle();
    tick();
    chk_val("t3_sticky", 32'(viol_flags[0]), 32'd1);

    // 4: address change in a wait state, then timeout
    do_clr();
    PSEL = 4'b0001; PWRITE = 1; PADDR = 8'h10; PSTRB = 4'hF; PWDATA = 32'h1234;
    tick();
    PENABLE = 1;
    to_pulses = 0;
    for (int i = 0; i < 20; i++) begin
      if (i == 1) PADDR = 8'h14;
      tick();
      to_pulses += int'(viol_pulse[4]);
    end
    chk_val("t4_timeout_once", 32'(to_pulses), 32'd1);
    chk_val("t4_unstable", 32'(viol_flags[3]), 32'd1);
    PREADY = 1;
    tick();
    bus_idle();
    tick();

    // 5: missing access, read strobe, enable held after completion
    do_clr();
    PSEL = 4'b0010; PWRITE = 1; PSTRB = 4'hF;
    tick();
    bus_idle();
    tick();
    chk_val("t5_no_access", 32'(viol_pulse[2]), 32'd1);
    xfer(2, 0, 8'h30, 32'h0, 4'h3, 0, 0, nb);
    chk_val("t5_read_strb", 32'(viol_flags[5]), 32'd1);
    xfer(3, 1, 8'h34, 32'h55AA, 4'hF, 1, 0, nb);
    PENABLE = 1;
    tick();
    chk_val("t5_en_hold", 32'(viol_pulse[6]), 32'd1);
    bus_idle();
    tick();

    // 6: clear coinciding with a violation
    do_clr();
    xfer(0, 1, 8'h40, 32'h1, 4'hF, 0, 1, nb);
    clr = 1; PSEL = 4'b0101; PWRITE = 1; PSTRB = 4'hF;
    tick();
    clr = 0;
    chk_val("t6_flags", 32'(viol_flags), 32'h01);
    chk_val("t6_xfer", 32'(xfer_count), 32'd0);
    chk_val("t6_err", 32'(err_count), 32'd0);
    bus_idle();
    tick();

    // reset in the middle of an access
    PSEL = 4'b0010; PWRITE = 0; PSTRB = 4'h0;
    tick();
    PENABLE = 1;
    tick();
    #2 PRESET_n = 0;
    #1;
    chk_val("rst_mid_flags", 32'(viol_flags), 32'h0);
    chk_val("rst_mid_pulse", 32'(viol_pulse), 32'h0);
    chk_val("rst_mid_busy", 32'(busy), 32'h0);
    chk_val("rst_mid_cnt", 32'({xfer_count, err_count}), 32'h0);
    model_reset();
    bus_idle();
    #2 PRESET_n = 1;
    tick();

    // counter saturation
    do_clr();
    for (int i = 0; i < 18; i++) xfer(i % 4, 1, 8'(i), 32'(i), 4'hF, 0, 1, nb);
    chk_val("sat_xfer", 32'(xfer_count), 32'd15);
    chk_val("sat_err", 32'(err_count), 32'd15);
    tick();

    // random traffic
    do_clr();
    for (int it = 0; it < 400; it++) begin
      r = $urandom_range(0, 9);
      if (r <= 5) begin
        w = ($urandom_range(0, 19) == 0) ? $urandom_range(15, 18) : $urandom_range(0, 3);
        s = 4'($urandom);
        if (r == 5) xfer($urandom_range(0, 3), 0, 8'($urandom), 32'($urandom), 4'h0, w,
                         1'($urandom), nb);
        else xfer($urandom_range(0, 3), 1, 8'($urandom), 32'($urandom), s, w,
                  1'($urandom), nb);
      end else if (r <= 7) begin
        for (int k = 0; k < 3; k++) begin
          PSEL = 4'($urandom); PENABLE = 1'($urandom); PWRITE = 1'($urandom);
          PADDR = 8'($urandom_range(0, 3)); PWDATA = 32'($urandom_range(0, 1));
          PSTRB = 4'($urandom_range(0, 1)); PREADY = 1'($urandom); PSLVERR = 1'($urandom);
          clr = ($urandom_range(0, 15) == 0);
          tick();
        end
        clr = 0;
        bus_idle();
      end else if (r == 8) begin
        xfer(0, 1, 8'h50, 32'($urandom), 4'hF, 0, 0, nb);
        xfer(1, 1, 8'h54, 32'($urandom), 4'h3, 1, 0, nb);
      end else begin
        bus_idle();
        tick();
      end
    end
    bus_idle();
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
